// File: rtl/slave_monitor_capture_if.sv
// slave_monitor_capture_if: SPI slave-side pins plus FIFO drain handshake.
// Parameters DATA_WIDTH/FIFO_DEPTH must match the attached capture block.
// slave : capture block (reads pins, rd_ready, overflow_clr; drives FIFO side)
// master: pin driver / consumer (drives pins and rd_ready, observes FIFO side)
interface slave_monitor_capture_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_mosi;
    logic [DATA_WIDTH-1:0] rd_miso;
    logic                  short_frame;
    logic                  overflow;
    logic                  overflow_clr;
    logic [LW-1:0]         level;

    modport slave (
        input  sclk, cs_n, mosi, miso, rd_ready, overflow_clr,
        output rd_valid, rd_mosi, rd_miso, short_frame, overflow, level
    );

    modport master (
        output sclk, cs_n, mosi, miso, rd_ready, overflow_clr,
        input  rd_valid, rd_mosi, rd_miso, short_frame, overflow, level
    );
endinterface

// File: rtl/slave_monitor_capture.sv
// slave_monitor_capture: oversampled SPI slave-pin capture into a word-pair FIFO.
// Assembles MSB-first MOSI/MISO words on the sampling edge and buffers them.
// Ports: pclk (system clock), preset (sync active-high reset),
//        bus (slave modport): sclk/cs_n/mosi/miso pins, rd_valid/rd_ready/
//        rd_mosi/rd_miso drain handshake, short_frame pulse, sticky overflow
//        with overflow_clr, level = FIFO occupancy.
// Option: define SLAVE_MONITOR_CAPTURE_SYNC_EN for 2-flop pin synchronizers.
module slave_monitor_capture #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input logic                    pclk,
    input logic                    preset,
    slave_monitor_capture_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic IDLE_LVL = (CPOL != 0);
    localparam bit RISE_EDGE = ((CPOL != 0) == (CPHA != 0));
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic s_sclk;
    logic s_cs;
    logic s_mosi;
    logic s_miso;

`ifdef SLAVE_MONITOR_CAPTURE_SYNC_EN
    logic [1:0] sync_sclk;
    logic [1:0] sync_cs;
    logic [1:0] sync_mosi;
    logic [1:0] sync_miso;

    always_ff @(posedge pclk) begin
        if (preset) begin
            sync_sclk <= {2{IDLE_LVL}};
            sync_cs   <= 2'b11;
            sync_mosi <= 2'b00;
            sync_miso <= 2'b00;
        end else begin
            sync_sclk <= {sync_sclk[0], bus.sclk};
            sync_cs   <= {sync_cs[0], bus.cs_n};
            sync_mosi <= {sync_mosi[0], bus.mosi};
            sync_miso <= {sync_miso[0], bus.miso};
        end
    end

    assign s_sclk = sync_sclk[1];
    assign s_cs   = sync_cs[1];
    assign s_mosi = sync_mosi[1];
    assign s_miso = sync_miso[1];
`else
    assign s_sclk = bus.sclk;
    assign s_cs   = bus.cs_n;
    assign s_mosi = bus.mosi;
    assign s_miso = bus.miso;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0] mosi_sr, mosi_d;
    logic [DATA_WIDTH-2:0] miso_sr, miso_d;
    logic                  sclk_q;
    logic                  cs_q;
    logic                  armed_q;
    logic                  short_q, short_d;
    logic                  push;
    logic                  samp_edge;
    logic                  cs_rise;
    logic [DATA_WIDTH-1:0] word_mosi;
    logic [DATA_WIDTH-1:0] word_miso;

    assign samp_edge = RISE_EDGE ? (s_sclk & ~sclk_q) : (~s_sclk & sclk_q);
    assign cs_rise   = s_cs & ~cs_q;
    // The word being completed includes the bit sampled this cycle.
    assign word_mosi = {mosi_sr, s_mosi};
    assign word_miso = {miso_sr, s_miso};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mosi_d  = mosi_sr;
        miso_d  = miso_sr;
        push    = 1'b0;
        short_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                mosi_d = '0;
                miso_d = '0;
                // armed_q: cs_n must be seen high after reset before a frame.
                if (armed_q && !s_cs) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    short_d = (cnt_q != '0);
                    cnt_d   = '0;
                    mosi_d  = '0;
                    miso_d  = '0;
                end else if (samp_edge) begin
                    mosi_d = word_mosi[DATA_WIDTH-2:0];
                    miso_d = word_miso[DATA_WIDTH-2:0];
                    if (cnt_q == LAST) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mosi_sr <= '0;
            miso_sr <= '0;
            sclk_q  <= IDLE_LVL;
            cs_q    <= 1'b1;
            armed_q <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mosi_sr <= mosi_d;
            miso_sr <= miso_d;
            sclk_q  <= s_sclk;
            cs_q    <= s_cs;
            armed_q <= armed_q | s_cs;
            short_q <= short_d;
        end
    end

    logic [DATA_WIDTH-1:0] mem_mosi [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_miso [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [LW-1:0]         count_q;
    logic                  ovf_q;
    logic                  rd_valid;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  ovf_set;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == LW'(FIFO_DEPTH));
    assign pop      = rd_valid & bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en    = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem_mosi[wr_ptr_q] <= word_mosi;
            mem_miso[wr_ptr_q] <= word_miso;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_set) ovf_q <= 1'b1;
            else if (bus.overflow_clr) ovf_q <= 1'b0;
        end
    end

    assign bus.rd_valid    = rd_valid;
    assign bus.rd_mosi     = rd_valid ? mem_mosi[rd_ptr_q] : '0;
    assign bus.rd_miso     = rd_valid ? mem_miso[rd_ptr_q] : '0;
    assign bus.short_frame = short_q;
    assign bus.overflow    = ovf_q;
    assign bus.level       = count_q;
endmodule

// File: tb/tb_slave_monitor_capture.sv
// tb_slave_monitor_capture: directed bench with a queue-based reference model.
// Two DUTs: mode (CPOL0,CPHA0) and (CPOL1,CPHA0) fed with inverted sclk.
module tb_slave_monitor_capture;
    logic pclk = 1'b0;
    logic preset;
    logic sclk, cs_n, mosi, miso, rd_ready, overflow_clr;

    always #5 pclk = ~pclk;

    slave_monitor_capture_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus_a ();
    slave_monitor_capture_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) bus_b ();

    assign bus_a.sclk = sclk;
    assign bus_a.cs_n = cs_n;
    assign bus_a.mosi = mosi;
    assign bus_a.miso = miso;
    assign bus_a.rd_ready = rd_ready;
    assign bus_a.overflow_clr = overflow_clr;
    assign bus_b.sclk = ~sclk;
    assign bus_b.cs_n = cs_n;
    assign bus_b.mosi = mosi;
    assign bus_b.miso = miso;
    assign bus_b.rd_ready = rd_ready;
    assign bus_b.overflow_clr = overflow_clr;

    slave_monitor_capture #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0)
    ) dut_a (.pclk(pclk), .preset(preset), .bus(bus_a));

    slave_monitor_capture #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1), .CPHA(0)
    ) dut_b (.pclk(pclk), .preset(preset), .bus(bus_b));

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] s;
    } pair_t;

    int total = 0;
    int bad = 0;

    // reference model state
    pair_t mq[$];
    pair_t log_q[$];
    int    m_nb;
    logic [7:0] m_mw, m_sw;
    bit    m_active, m_armed, m_ovf, m_sf, m_psclk, m_pcs;
    int    sf_count = 0;
    int    sf_seen_a = 0;
`ifdef SLAVE_MONITOR_CAPTURE_SYNC_EN
    logic [3:0] m_d0, m_d1;
`endif

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] p;
        bit pop, push, full;
        pair_t w;
        w = '0;
`ifdef SLAVE_MONITOR_CAPTURE_SYNC_EN
        p = m_d1;
        m_d1 = m_d0;
        m_d0 = {sclk, cs_n, mosi, miso};
`else
        p = {sclk, cs_n, mosi, miso};
`endif
        if (preset) begin
            mq.delete();
            m_nb = 0; m_mw = 0; m_sw = 0;
            m_active = 0; m_armed = 0; m_ovf = 0; m_sf = 0;
            m_psclk = 0; m_pcs = 1;
`ifdef SLAVE_MONITOR_CAPTURE_SYNC_EN
            m_d0 = 4'b0100; m_d1 = 4'b0100;
`endif
            return;
        end
        pop = (mq.size() != 0) && rd_ready;
        full = (mq.size() == 4);
        push = 0;
        m_sf = 0;
        if (!m_active) begin
            m_nb = 0; m_mw = 0; m_sw = 0;
            if (m_armed && !p[2]) m_active = 1;
            if (p[2]) m_armed = 1;
        end else if (p[2]) begin
            if (m_nb != 0) begin
                m_sf = 1;
                sf_count++;
            end
            m_active = 0;
            m_nb = 0;
        end else if (p[3] && !m_psclk) begin
            m_mw = {m_mw[6:0], p[1]};
            m_sw = {m_sw[6:0], p[0]};
            m_nb++;
            if (m_nb == 8) begin
                push = 1;
                w = '{m: m_mw, s: m_sw};
                m_nb = 0;
            end
        end
        if (push && full && !pop) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        if (pop) log_q.push_back(mq.pop_front());
        if (push && (!full || pop)) mq.push_back(w);
        m_psclk = p[3];
        m_pcs = p[2];
    endtask

    task automatic cmp_dut(string tag, logic v, logic [7:0] dm, logic [7:0] ds,
                           logic sf, logic ovf, logic [2:0] lvl);
        pair_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".rd_valid"}, v, (mq.size() != 0));
        chk({tag, ".rd_mosi"}, dm, h.m);
        chk({tag, ".rd_miso"}, ds, h.s);
        chk({tag, ".short_frame"}, sf, m_sf);
        chk({tag, ".overflow"}, ovf, m_ovf);
        chk({tag, ".level"}, lvl, mq.size());
    endtask

    always @(posedge pclk) begin
        model_step();
        #1;
        cmp_dut("a", bus_a.rd_valid, bus_a.rd_mosi, bus_a.rd_miso,
                bus_a.short_frame, bus_a.overflow, bus_a.level);
        cmp_dut("b", bus_b.rd_valid, bus_b.rd_mosi, bus_b.rd_miso,
                bus_b.short_frame, bus_b.overflow, bus_b.level);
        if (bus_a.short_frame) sf_seen_a++;
    end

    task automatic tick(int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_bits(logic [7:0] mw, logic [7:0] sw, int n, bit pop_last);
        for (int i = 0; i < n; i++) begin
            sclk = 0;
            mosi = mw[7-i];
            miso = sw[7-i];
            tick(2);
            sclk = 1;
            if (pop_last && i == n - 1) rd_ready = 1;
            tick(1);
            if (pop_last && i == n - 1) rd_ready = 0;
            tick(1);
        end
        sclk = 0;
        tick(2);
    endtask

    task automatic cs_lo();
        cs_n = 0;
        tick(2);
    endtask

    task automatic cs_hi();
        cs_n = 1;
        tick(3);
    endtask

    task automatic drain();
        rd_ready = 1;
        for (int k = 0; k < 20 && mq.size() != 0; k++) tick(1);
        chk("drain_done", mq.size(), 0);
        rd_ready = 0;
        tick(1);
    endtask

    task automatic chk_log(string name, int idx, logic [7:0] em, logic [7:0] es);
        pair_t e;
        e = '{m: em, s: es};
        if (idx < log_q.size()) chk(name, log_q[idx], e);
        else chk({name, ".missing"}, log_q.size(), idx + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        preset = 1; sclk = 0; cs_n = 1; mosi = 0; miso = 0;
        rd_ready = 0; overflow_clr = 0;
        tick(3);
        chk("rst.level", bus_a.level, 0);
        chk("rst.rd_valid", bus_a.rd_valid, 0);
        chk("rst.rd_mosi", bus_a.rd_mosi, 0);
        chk("rst.rd_miso", bus_a.rd_miso, 0);
        chk("rst.overflow", bus_a.overflow, 0);
        chk("rst.short_frame", bus_a.short_frame, 0);
        preset = 0;
        tick(2);

        // single word, consumer always ready
        log_q.delete();
        rd_ready = 1;
        cs_lo();
        send_bits(8'hA5, 8'h3C, 8, 0);
        cs_hi();
        tick(2);
        rd_ready = 0;
        chk("t1.pops", log_q.size(), 1);
        chk_log("t1.word", 0, 8'hA5, 8'h3C);
        chk("t1.sf_model", sf_count, 0);
        chk("t1.sf_dut", sf_seen_a, 0);
        chk("t1.level", bus_a.level, 0);

        // back-to-back words, consumer stalled
        log_q.delete();
        cs_lo();
        send_bits(8'h01, 8'hFE, 8, 0);
        send_bits(8'h80, 8'h7F, 8, 0);
        send_bits(8'hFF, 8'h00, 8, 0);
        cs_hi();
        chk("t2.level_a", bus_a.level, 3);
        chk("t2.level_b", bus_b.level, 3);
        chk("t2.head_a", bus_a.rd_mosi, 8'h01);
        chk("t2.head_b", bus_b.rd_miso, 8'hFE);
        drain();
        chk_log("t2.w0", 0, 8'h01, 8'hFE);
        chk_log("t2.w1", 1, 8'h80, 8'h7F);
        chk_log("t2.w2", 2, 8'hFF, 8'h00);

        // short frame then a full word
        log_q.delete();
        cs_lo();
        send_bits(8'hB0, 8'h4F, 5, 0);
        cs_hi();
        chk("t3.sf_model", sf_count, 1);
        chk("t3.sf_dut", sf_seen_a, 1);
        chk("t3.level", bus_a.level, 0);
        cs_lo();
        send_bits(8'h5A, 8'hC3, 8, 0);
        cs_hi();
        chk("t3.level2", bus_a.level, 1);
        chk("t3.head", bus_a.rd_mosi, 8'h5A);
        drain();
        chk_log("t3.w0", 0, 8'h5A, 8'hC3);

        // overflow with five words into depth four
        log_q.delete();
        cs_lo();
        send_bits(8'h11, 8'hEE, 8, 0);
        send_bits(8'h22, 8'hDD, 8, 0);
        send_bits(8'h33, 8'hCC, 8, 0);
        send_bits(8'h44, 8'hBB, 8, 0);
        send_bits(8'h55, 8'hAA, 8, 0);
        cs_hi();
        chk("t4.level", bus_a.level, 4);
        chk("t4.overflow", bus_a.overflow, 1);
        chk("t4.head", bus_a.rd_mosi, 8'h11);
        overflow_clr = 1;
        tick(1);
        overflow_clr = 0;
        chk("t4.ovf_clr", bus_a.overflow, 0);

        // full FIFO: push and pop in the same cycle
        cs_lo();
        send_bits(8'h66, 8'h99, 8, 1);
        cs_hi();
        chk("t5.overflow", bus_a.overflow, 0);
        chk("t5.level", bus_a.level, 4);
        chk("t5.head", bus_a.rd_mosi, 8'h22);
        drain();
        chk_log("t5.w0", 0, 8'h11, 8'hEE);
        chk_log("t5.w1", 1, 8'h22, 8'hDD);
        chk_log("t5.w4", 4, 8'h66, 8'h99);

        // reset mid-word with two words buffered
        log_q.delete();
        cs_lo();
        send_bits(8'h81, 8'h18, 8, 0);
        send_bits(8'h42, 8'h24, 8, 0);
        send_bits(8'hF0, 8'h0F, 4, 0);
        chk("t6.pre_level", bus_a.level, 2);
        preset = 1;
        tick(1);
        preset = 0;
        chk("t6.level", bus_a.level, 0);
        chk("t6.rd_valid", bus_a.rd_valid, 0);
        send_bits(8'hC3, 8'h3C, 8, 0);
        chk("t6.no_capture", bus_a.level, 0);
        cs_hi();
        cs_lo();
        send_bits(8'h3C, 8'hA5, 8, 0);
        cs_hi();
        chk("t6.level2", bus_a.level, 1);
        chk("t6.head", bus_a.rd_mosi, 8'h3C);
        drain();
        chk_log("t6.w0", 0, 8'h3C, 8'hA5);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/slave_monitor_capture.md
# slave_monitor_capture

Pin-level capture stage feeding `slave_monitor_bfm`. It oversamples the SPI slave-side pins (`sclk`, `cs_n`, `mosi`, `miso`) on the system clock and detects the configured sampling edge. It assembles MSB-first words for both data lines and buffers the completed word pairs in a small FIFO. The BFM drains the FIFO through a valid/ready handshake and forwards each pair to the monitor proxy.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per word; legal 2..32.
- `FIFO_DEPTH`, 4: word-pair entries; power of two, 2..16.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: sampling phase. Sampling edge is rising when `CPOL^CPHA==0`, otherwise falling.

Ports:
- `pclk`, in, 1: system clock. The single clock of the block.
- `preset`, in, 1: reset, synchronous, active-high.
- `sclk`, in, 1: serial clock. Sampled as data; requires f(pclk) ≥ 4×f(sclk).
- `cs_n`, in, 1: slave select, active-low.
- `mosi`, in, 1: master-out serial data.
- `miso`, in, 1: slave-out serial data.
- `rd_valid`, out, 1: FIFO head holds a word pair.
- `rd_ready`, in, 1: consumer accepts the head. A pop occurs when `rd_valid && rd_ready`.
- `rd_mosi`, out, DATA_WIDTH: head MOSI word.
- `rd_miso`, out, DATA_WIDTH: head MISO word.
- `short_frame`, out, 1: one-cycle pulse when `cs_n` rises with a partial word pending.
- `overflow`, out, 1: sticky flag set when a word is dropped because the FIFO is full.
- `overflow_clr`, in, 1: clears `overflow`.
- `level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Input path: the optional synchronizer (see Configuration) feeds the registers `sclk_q`/`cs_q`. An edge is detected when the current synchronized `sclk` differs from `sclk_q` in the configured sampling direction.
- FSM states:
  - IDLE: `cs_q==1`. Bit counter is held at 0 and the shift registers are cleared. A synchronized `cs_n` value of 0 moves the FSM to ACTIVE.
  - ACTIVE: on each sampling edge, the synchronized `mosi`/`miso` are shifted into the LSB and the counter increments.
    - When the counter reaches DATA_WIDTH-1 on an edge, the completed pair (including the current bit) is written to the FIFO in the same cycle and the counter returns to 0.
    - Back-to-back words within one `cs_n` assertion are supported.
  - ACTIVE, `cs_n` rises: if the counter is non-zero, pulse `short_frame` and discard the partial word. In either case, return to IDLE.
  - An `sclk` edge in the same cycle as the `cs_n` rise is ignored.
- FIFO:
  - Write while full with no pop in that cycle: the word is dropped and `overflow` is set.
  - Write and pop in the same cycle while full: both succeed and `overflow` is not set.
  - Read on empty is impossible because `rd_valid==0`.
- `overflow_clr` clears `overflow`. If a set condition occurs in the same cycle, set wins.
- `rd_mosi`/`rd_miso` hold the head value while `rd_valid` is high, and are stable until popped.

## Timing
- Reset values:
  - Outputs: `rd_valid=0`, `rd_mosi=0`, `rd_miso=0`, `short_frame=0`, `overflow=0`, `level=0`.
  - Internal state: FSM is in IDLE, FIFO is empty, `sclk_q` is loaded with CPOL, and `cs_q` is loaded with 1.
- If reset is asserted mid-frame, the partial word and FIFO contents are lost. After reset is released, capture resumes only after `cs_n` has been seen high (IDLE), then low again.
- Latency:
  - From the pin edge to the shift-register update: 1 cycle, plus synchronizer depth.
  - From the last-bit edge-detect cycle to `rd_valid` high: 1 cycle.
  - After a pop, the next head appears and `rd_valid` updates in the following cycle, giving 1 pop/cycle sustained.
- `short_frame` asserts the cycle after the `cs_q` rise is registered.
- `level` updates one cycle after the push or pop.

## Configuration
- `SLAVE_MONITOR_CAPTURE_SYNC_EN`:
  - Defined: all four pin inputs pass through 2-flop synchronizers reset to {CPOL,1,0,0}, adding 2 cycles to every pin-related latency.
  - Undefined: pins feed `sclk_q`/`cs_q` and the shift logic directly, with no added latency. In this mode the pins must be synchronous to `pclk`.

## Test plan
- DATA_WIDTH=8, CPOL=0, CPHA=0: drive `cs_n` low, send MOSI 0xA5 / MISO 0x3C, then `cs_n` high, with `rd_ready` held at 1. Expect one `rd_valid` pulse carrying `rd_mosi`=0xA5 and `rd_miso`=0x3C, and `short_frame`=0.
- CPOL=1, CPHA=0 (falling-edge sampling): back-to-back words 0x01, 0x80, 0xFF under one `cs_n` assertion. Expect three FIFO entries in order and `level` peaking at 3 with `rd_ready` held at 0.
- Raise `cs_n` after 5 bits. Expect `short_frame` to pulse for 1 cycle, no FIFO write, and a following full word captured correctly.
- With `rd_ready` held at 0, send 5 words with FIFO_DEPTH=4. Expect `level`=4, `overflow`=1, and the first four words retained. Pulse `overflow_clr` and expect `overflow`=0.
- With the FIFO full, complete a word in the same cycle as a pop. Expect `overflow` to stay 0, `level` to stay 4, and the new word to be appended.
- Assert `preset` mid-word with 2 words in the FIFO. Expect `level`=0 and `rd_valid`=0 the next cycle. With `cs_n` still low there is no capture until `cs_n` goes high and then low again.
